led_scan_reader: RTL and testbench



---
 rtl/led_scan_reader.sv | 141 ++++++++++++++
 tb/tb_led_scan_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_reader.sv
// Readback monitor for a multiplexed 4-digit seven-segment display: recovers the hex
// character on each digit once its anode/segment pattern has settled.
module led_scan_reader #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  LED,
    output logic [15:0] chars,
    output logic [3:0]  valid,
    output logic [3:0]  bad,
    output logic        update,
    output logic [1:0]  upd_digit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [10:0]      sample;
    logic             changed;
    logic             one_hot;
    logic [1:0]       digit;
    logic             capture;
    logic             legal;
    logic             blank;
    logic [3:0]       code;

    // Returns {legal, code}; segments are active-low {a,b,c,d,e,f,g}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0000001: res = 5'h10;
            7'b1001111: res = 5'h11;
            7'b0010010: res = 5'h12;
            7'b0000110: res = 5'h13;
            7'b1001100: res = 5'h14;
            7'b0100100: res = 5'h15;
            7'b0100000: res = 5'h16;
            7'b0001111: res = 5'h17;
            7'b0000000: res = 5'h18;
            7'b0000100: res = 5'h19;
            7'b0001000: res = 5'h1A;
            7'b1100000: res = 5'h1B;
            7'b0110001: res = 5'h1C;
            7'b1000010: res = 5'h1D;
            7'b0110000: res = 5'h1E;
            7'b0111000: res = 5'h1F;
            default:    res = 5'h00;
        endcase
        return res;
    endfunction

    // Returns {one_hot_low, digit index}.
    function automatic logic [2:0] select_digit(input logic [3:0] anodes);
        logic [2:0] res;
        case (anodes)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    assign changed           = ({an, LED} != sample);
    assign {one_hot, digit}  = select_digit(an);
    assign {legal, code}     = decode_glyph(LED);
    assign blank             = (LED == 7'h7F);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            sample <= 11'h7FF;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sample <= {an, LED};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (changed) begin
            cnt_nxt   = '0;
            state_nxt = one_hot ? SETTLE : IDLE;
        end else if (state == SETTLE) begin
            if (cnt == LAST_CNT) begin
                state_nxt = HELD;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // SETTLE is only entered on a one-hot anode, so digit is meaningful here.
    always_comb begin
        capture = 1'b0;
        if (state == SETTLE && !changed && cnt == LAST_CNT) begin
            capture = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chars     <= '0;
            valid     <= '0;
            bad       <= '0;
            update    <= 1'b0;
            upd_digit <= '0;
        end else begin
            update <= capture;
            if (capture) begin
                upd_digit <= digit;
                if (legal) begin
                    chars[{digit, 2'b00} +: 4] <= code;
                    valid[digit]               <= 1'b1;
                    bad[digit]                 <= 1'b0;
                end else begin
                    valid[digit] <= 1'b0;
                    bad[digit]   <= !blank;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_scan_reader.sv
// Bench for led_scan_reader: directed scenarios plus random hold patterns, all compared
// each cycle against a run-length reference model of the display readback.
module tb_led_scan_reader;

    localparam int STABLE = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  led;
    logic [15:0] chars;
    logic [3:0]  valid;
    logic [3:0]  bad_flags;
    logic        update;
    logic [1:0]  upd_digit;

    int n_total = 0;
    int n_bad   = 0;

    led_scan_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .an(an), .LED(led), .chars(chars),
        .valid(valid), .bad(bad_flags), .update(update), .upd_digit(upd_digit)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: a digit is read once its {an,LED} value has been seen on
    // STABLE+1 consecutive edges, counting the edge where it first appeared.
    logic [10:0] m_prev;
    int          m_run;
    logic        m_upd;
    logic [1:0]  m_dig;
    logic [15:0] m_chars;
    logic [3:0]  m_valid;
    logic [3:0]  m_bad;

    function automatic void model_reset();
        m_prev  = 11'h7FF;
        m_run   = 0;
        m_upd   = 1'b0;
        m_dig   = 2'd0;
        m_chars = '0;
        m_valid = '0;
        m_bad   = '0;
    endfunction

    function automatic void model_edge(input logic [3:0] a, input logic [6:0] l);
        int zeros = 0;
        int d = 0;
        int code = -1;
        if ({a, l} != m_prev) m_run = 1;
        else m_run++;
        m_prev = {a, l};
        m_upd  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] == 1'b0) begin
                zeros++;
                d = i;
            end
        end
        if (m_run == STABLE + 1 && zeros == 1) begin
            for (int g = 0; g < 16; g++) if (glyph_tab[g] == l) code = g;
            m_upd = 1'b1;
            m_dig = 2'(d);
            if (code >= 0) begin
                m_chars[d*4 +: 4] = 4'(code);
                m_valid[d] = 1'b1;
                m_bad[d]   = 1'b0;
            end else begin
                m_valid[d] = 1'b0;
                m_bad[d]   = (l != 7'h7F);
            end
        end
    endfunction

    task automatic cyc(input logic [3:0] a, input logic [6:0] l);
        an  = a;
        led = l;
        @(posedge clk);
        #1;
        model_edge(a, l);
    endtask

    task automatic test_reset();
        logic [26:0] obs;
        reset = 1'b0;
        an    = 4'hF;
        led   = 7'h7F;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        obs = {update, upd_digit, chars, valid, bad_flags};
        n_total++;
        if (obs !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [26:0] obs, exp_v;
        int pulses = 0;
        int at = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(4'b1110, 7'b0000001);
            obs   = {update, update ? upd_digit : 2'd0, chars, valid, bad_flags};
            exp_v = {m_upd, m_upd ? m_dig : 2'd0, m_chars, m_valid, m_bad};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL single cyc%0d: got %h want %h", i, obs, exp_v);
            end
            if (update) begin
                pulses++;
                at = i;
            end
        end
        n_total++;
        if (pulses != 1 || at != 1 + STABLE) begin
            n_bad++;
            $display("FAIL single_latency: got %0d pulses at cyc%0d want 1 at cyc%0d", pulses, at, 1 + STABLE);
        end
        n_total++;
        if ({chars[3:0], valid, bad_flags} !== {4'h0, 4'b0001, 4'b0000}) begin
            n_bad++;
            $display("FAIL single_final: got %h/%b/%b want 0/0001/0000", chars[3:0], valid, bad_flags);
        end
    endtask

    task automatic test_restart();
        logic [26:0] obs, exp_v;
        int pulses = 0;
        for (int i = 0; i < STABLE; i++) cyc(4'b1110, 7'b1001111);
        for (int i = 1; i <= 12; i++) begin
            cyc(4'b1110, 7'b0010010);
            obs   = {update, update ? upd_digit : 2'd0, chars, valid, bad_flags};
            exp_v = {m_upd, m_upd ? m_dig : 2'd0, m_chars, m_valid, m_bad};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL restart cyc%0d: got %h want %h", i, obs, exp_v);
            end
            if (update) pulses++;
        end
        n_total++;
        if (pulses != 1 || chars[3:0] !== 4'h2) begin
            n_bad++;
            $display("FAIL restart_final: got %0d pulses chars0=%h want 1 pulse chars0=2", pulses, chars[3:0]);
        end
    endtask

    task automatic test_scan();
        logic [26:0] obs, exp_v;
        logic [3:0] ans  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] pats [4] = '{7'b0000110, 7'b0001000, 7'b1000010, 7'b0111000};
        int seen [$];
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 10; i++) begin
                cyc(ans[d], pats[d]);
                obs   = {update, update ? upd_digit : 2'd0, chars, valid, bad_flags};
                exp_v = {m_upd, m_upd ? m_dig : 2'd0, m_chars, m_valid, m_bad};
                n_total++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL scan d%0d cyc%0d: got %h want %h", d, i, obs, exp_v);
                end
                if (update) seen.push_back(int'(upd_digit));
            end
        end
        n_total++;
        if (seen.size() != 4 || seen[0] != 0 || seen[1] != 1 || seen[2] != 2 || seen[3] != 3) begin
            n_bad++;
            $display("FAIL scan_order: got %0d pulses want 4 in order 0..3", seen.size());
        end
        n_total++;
        if (chars !== 16'hFDA3 || valid !== 4'b1111) begin
            n_bad++;
            $display("FAIL scan_final: got chars=%h valid=%b want FDA3 1111", chars, valid);
        end
    endtask

    task automatic test_illegal();
        logic [26:0] obs, exp_v;
        int pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(4'b1011, 7'b1111110);
            obs   = {update, update ? upd_digit : 2'd0, chars, valid, bad_flags};
            exp_v = {m_upd, m_upd ? m_dig : 2'd0, m_chars, m_valid, m_bad};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL illegal cyc%0d: got %h want %h", i, obs, exp_v);
            end
            if (update && upd_digit == 2'd2) pulses++;
        end
        n_total++;
        if (pulses != 1 || bad_flags !== 4'b0100 || valid[2] !== 1'b0 || chars[11:8] !== 4'hD) begin
            n_bad++;
            $display("FAIL illegal_final: got pulses=%0d bad=%b valid=%b chars=%h want 1 0100 x0xx D", pulses, bad_flags, valid, chars);
        end
    endtask

    task automatic test_toggle();
        logic [26:0] obs, exp_v;
        logic [6:0] pat;
        logic [15:0] c0 = chars;
        logic [3:0] v0 = valid;
        logic [3:0] b0 = bad_flags;
        int pulses = 0;
        for (int t = 0; t < 5; t++) begin
            pat = t[0] ? 7'b0000100 : 7'b0000000;
            for (int i = 0; i < STABLE - 1; i++) begin
                cyc(4'b1101, pat);
                obs   = {update, update ? upd_digit : 2'd0, chars, valid, bad_flags};
                exp_v = {m_upd, m_upd ? m_dig : 2'd0, m_chars, m_valid, m_bad};
                n_total++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL toggle t%0d cyc%0d: got %h want %h", t, i, obs, exp_v);
                end
                if (update) pulses++;
            end
        end
        n_total++;
        if (pulses != 0 || chars !== c0 || valid !== v0 || bad_flags !== b0) begin
            n_bad++;
            $display("FAIL toggle_final: got %0d pulses, fields changed=%0d want 0 and unchanged", pulses, int'({chars, valid, bad_flags} !== {c0, v0, b0}));
        end
    endtask

    task automatic test_non_onehot();
        logic [26:0] obs, exp_v;
        logic [3:0] ans [2] = '{4'b0011, 4'b1111};
        int pulses = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 30; i++) begin
                cyc(ans[k], 7'b0000000);
                obs   = {update, update ? upd_digit : 2'd0, chars, valid, bad_flags};
                exp_v = {m_upd, m_upd ? m_dig : 2'd0, m_chars, m_valid, m_bad};
                n_total++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL nonhot an=%b cyc%0d: got %h want %h", ans[k], i, obs, exp_v);
                end
                if (update) pulses++;
            end
        end
        n_total++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL nonhot_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_blank_and_reset();
        logic [26:0] obs, exp_v;
        int pulses = 0;
        for (int i = 0; i < 10; i++) cyc(4'b1101, 7'b0100100);
        n_total++;
        if (chars[7:4] !== 4'h5 || valid[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL five_capture: got chars1=%h valid1=%b want 5 1", chars[7:4], valid[1]);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(4'b1101, 7'b1111111);
            obs   = {update, update ? upd_digit : 2'd0, chars, valid, bad_flags};
            exp_v = {m_upd, m_upd ? m_dig : 2'd0, m_chars, m_valid, m_bad};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL blank cyc%0d: got %h want %h", i, obs, exp_v);
            end
            if (update && upd_digit == 2'd1) pulses++;
        end
        n_total++;
        if (pulses != 1 || valid[1] !== 1'b0 || bad_flags[1] !== 1'b0 || chars[7:4] !== 4'h5) begin
            n_bad++;
            $display("FAIL blank_final: got pulses=%0d valid1=%b bad1=%b chars1=%h want 1 0 0 5", pulses, valid[1], bad_flags[1], chars[7:4]);
        end
        reset = 1'b0;
        #2;
        obs = {update, upd_digit, chars, valid, bad_flags};
        n_total++;
        if (obs !== 27'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0 before next edge", obs);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [26:0] obs, exp_v;
        logic [3:0] a;
        logic [6:0] l;
        int hold;
        int sel;
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) a = ~(4'b0001 << $urandom_range(0, 3));
            else a = 4'($urandom);
            sel = $urandom_range(0, 19);
            if (sel < 10) l = glyph_tab[$urandom_range(0, 15)];
            else if (sel < 13) l = 7'h7F;
            else l = 7'($urandom);
            hold = $urandom_range(1, 12);
            for (int i = 0; i < hold; i++) begin
                cyc(a, l);
                obs   = {update, update ? upd_digit : 2'd0, chars, valid, bad_flags};
                exp_v = {m_upd, m_upd ? m_dig : 2'd0, m_chars, m_valid, m_bad};
                n_total++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL random seg%0d cyc%0d an=%b led=%b: got %h want %h", s, i, a, l, obs, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_restart();
        test_scan();
        test_illegal();
        test_toggle();
        test_non_onehot();
        test_blank_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
